// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: EX handshake, data-bus request/ack, load extension
//
// Optional feature: define LSU_TIMEOUT_EN to enable the bus timeout counter
// (TIMEOUT_CYCLES, 2..255). Without it, BUS waits for data_ack indefinitely.
//
// Ports:
//   clk, reset (async, active-low)
//   ex_valid/ex_ready handshake with ex_we, ex_size, ex_signed, ex_addr, ex_wdata, ex_rd
//   data_req/data_we/data_addr/data_be/data_out -> bus, data_ack/data_in <- bus
//   wb_valid/wb_addr/wb_data  register-file write-back (one-cycle strobe)
//   stall                     high whenever an operation is in flight
//   fault/fault_addr          one-cycle misalignment/timeout pulse, address held
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [2:0]  ex_rd,
    output logic        data_req,
    output logic        data_we,
    output logic [31:0] data_addr,
    output logic [3:0]  data_be,
    output logic [31:0] data_out,
    input  logic        data_ack,
    input  logic [31:0] data_in,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;

    state_t      state;
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [1:0]  op_off;
    logic [2:0]  op_rd;

    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] lanes_next;
    logic [31:0] shifted;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wait_cnt;
    logic [31:0] op_addr;
`endif

    // Both decode state directly; reset low must also block the handshake.
    assign ex_ready = reset && (state == IDLE);
    assign stall    = (state != IDLE);

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        lanes_next = ex_wdata;
        case (ex_size)
            2'b00: begin
                be_next    = 4'b0001 << ex_addr[1:0];
                lanes_next = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr[0];
                be_next    = 4'b0011 << ex_addr[1:0];
                lanes_next = {2{ex_wdata[15:0]}};
            end
            2'b10:   misaligned = (ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Word loads are always aligned, so the shifted value equals data_in for them.
    always_comb begin
        shifted = data_in >> {op_off, 3'b000};
        case (op_size)
            2'b00:   load_ext = {{24{op_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{op_signed & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_size    <= 2'b00;
            op_signed  <= 1'b0;
            op_off     <= 2'b00;
            op_rd      <= 3'd0;
            data_req   <= 1'b0;
            data_we    <= 1'b0;
            data_addr  <= 32'd0;
            data_be    <= 4'd0;
            data_out   <= 32'd0;
            wb_valid   <= 1'b0;
            wb_addr    <= 3'd0;
            wb_data    <= 32'd0;
            fault      <= 1'b0;
            fault_addr <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= 8'd0;
            op_addr    <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        op_we     <= ex_we;
                        op_size   <= ex_size;
                        op_signed <= ex_signed;
                        op_off    <= ex_addr[1:0];
                        op_rd     <= ex_rd;
`ifdef LSU_TIMEOUT_EN
                        op_addr   <= ex_addr;
                        wait_cnt  <= 8'd0;
`endif
                        if (misaligned) begin
                            fault      <= 1'b1;
                            fault_addr <= ex_addr;
                            state      <= FAULT;
                        end else begin
                            data_req  <= 1'b1;
                            data_we   <= ex_we;
                            data_addr <= {ex_addr[31:2], 2'b00};
                            data_be   <= be_next;
                            data_out  <= lanes_next;
                            state     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (data_ack) begin
                        data_req <= 1'b0;
                        data_we  <= 1'b0;
                        data_be  <= 4'd0;
                        if (op_we) begin
                            state <= IDLE;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_addr  <= op_rd;
                            wb_data  <= load_ext;
                            state    <= RESP;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    // Limit is reached by this ack-less cycle; an ack here would have won above.
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        data_req   <= 1'b0;
                        data_we    <= 1'b0;
                        data_be    <= 4'd0;
                        fault      <= 1'b1;
                        fault_addr <= op_addr;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                FAULT: begin
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [2:0]  ex_rd;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_out;
    logic        data_ack;
    logic [31:0] data_in;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        fault;
    logic [31:0] fault_addr;

    int passed = 0;
    int total  = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_size(ex_size),
        .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_be(data_be),
        .data_out(data_out), .data_ack(data_ack), .data_in(data_in),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .fault(fault), .fault_addr(fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] rd);
        ex_valid  = 1'b1;
        ex_we     = we;
        ex_size   = size;
        ex_signed = sgn;
        ex_addr   = addr;
        ex_wdata  = wdata;
        ex_rd     = rd;
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_size = 2'b00; ex_signed = 1'b0;
        ex_addr = '0; ex_wdata = '0; ex_rd = '0; data_ack = 1'b0; data_in = '0;
        tick(); tick();
        chk("rst_ex_ready", 32'(ex_ready), 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        reset = 1'b1;
        data_ack = 1'b1;   // ack while idle must be ignored
        tick();
        chk("idle_ex_ready", 32'(ex_ready), 32'd1);
        chk("idle_ack_ignored", 32'({data_req, wb_valid, stall}), 32'd0);
        data_ack = 1'b0;

        // store byte 0x1003, ack one cycle after request
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 3'd0);
        tick();
        ex_valid = 1'b0;
        chk("sb_req", 32'(data_req), 32'd1);
        chk("sb_we", 32'(data_we), 32'd1);
        chk("sb_addr", data_addr, 32'h0000_1000);
        chk("sb_be", 32'(data_be), 32'b1000);
        chk("sb_data", data_out, 32'hABAB_ABAB);
        chk("sb_ex_ready", 32'(ex_ready), 32'd0);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("sb_done_req", 32'(data_req), 32'd0);
        chk("sb_done_ready", 32'(ex_ready), 32'd1);
        chk("sb_no_wb", 32'(wb_valid), 32'd0);

        // store half 0x4002
        issue(1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h1234_BEEF, 3'd0);
        tick();
        ex_valid = 1'b0;
        chk("sh_be", 32'(data_be), 32'b1100);
        chk("sh_data", data_out, 32'hBEEF_BEEF);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;

        // load half signed 0x2002, three wait cycles, stall counted
        issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 3'd5);
        stall_cycles = 0;
        tick();
        ex_valid = 1'b0;
        chk("lh_be", 32'(data_be), 32'b1100);
        chk("lh_addr", data_addr, 32'h0000_2000);
        for (int i = 0; i < 8; i++) begin
            if (stall) stall_cycles++;
            if (i == 3) begin
                chk("lh_req_held", 32'(data_req), 32'd1);
                data_ack = 1'b1;
                data_in  = 32'h8001_1234;
            end else begin
                data_ack = 1'b0;
                data_in  = 32'h5555_5555;
            end
            tick();
            if (i == 3) begin
                chk("lh_wb_valid", 32'(wb_valid), 32'd1);
                chk("lh_wb_data", wb_data, 32'hFFFF_8001);
                chk("lh_wb_addr", 32'(wb_addr), 32'd5);
            end
            if (i == 4) begin
                chk("lh_wb_pulse", 32'(wb_valid), 32'd0);
                chk("lh_ready_back", 32'(ex_ready), 32'd1);
            end
        end
        chk("lh_stall_cycles", 32'(stall_cycles), 32'd5);

        // load byte, unsigned then signed, at offset 1
        issue(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 3'd2);
        tick();
        ex_valid = 1'b0;
        chk("lbu_be", 32'(data_be), 32'b0010);
        data_ack = 1'b1; data_in = 32'h1234_F678;
        tick();
        data_ack = 1'b0;
        chk("lbu_data", wb_data, 32'h0000_00F6);
        tick();
        issue(1'b0, 2'b00, 1'b1, 32'h0000_3001, 32'h0, 3'd2);
        tick();
        ex_valid = 1'b0;
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("lb_data", wb_data, 32'hFFFF_FFF6);
        tick();

        // misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 3'd1);
        tick();
        ex_valid = 1'b0;
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_addr", fault_addr, 32'h0000_0005);
        chk("mis_no_req", 32'(data_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd1);
        tick();
        chk("mis_fault_pulse", 32'(fault), 32'd0);
        chk("mis_ready", 32'(ex_ready), 32'd1);
        chk("mis_no_wb", 32'(wb_valid), 32'd0);

        // reserved size faults too
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 3'd0);
        tick();
        ex_valid = 1'b0;
        chk("rsv_fault", 32'({fault, data_req}), 32'b10);
        chk("rsv_fault_addr", fault_addr, 32'h0000_0100);
        tick();

        // back-to-back: store word then load word, ex_valid held high
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3'd0);
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 3'd3);
        chk("b2b_st_addr", data_addr, 32'h0000_0010);
        chk("b2b_st_be", 32'(data_be), 32'b1111);
        chk("b2b_st_data", data_out, 32'hDEAD_BEEF);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("b2b_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("b2b_ld_req", 32'({data_req, data_we}), 32'b10);
        chk("b2b_ld_addr", data_addr, 32'h0000_0020);
        data_ack = 1'b1; data_in = 32'hCAFE_F00D;
        tick();
        data_ack = 1'b0;
        chk("b2b_ld_wb", wb_data, 32'hCAFE_F00D);
        chk("b2b_ld_rd", 32'(wb_addr), 32'd3);
        tick();

        // reset during BUS
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 3'd4);
        tick();
        ex_valid = 1'b0;
        chk("rb_req", 32'(data_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rb_drop", 32'({data_req, wb_valid, stall, ex_ready}), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rb_after", 32'({ex_ready, stall, fault, wb_valid}), 32'b1000);

`ifdef LSU_TIMEOUT_EN
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 3'd6);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", 32'(data_req), 32'd1);
            tick();
        end
        chk("to_req_drop", 32'(data_req), 32'd0);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_fault_addr", fault_addr, 32'h0000_0080);
        tick();
        chk("to_ready", 32'({ex_ready, wb_valid, fault}), 32'b100);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
